// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers.
// Launches one byte per grant, tracks busy, enforces an inter-frame gap and a launch watchdog.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned D_WIDTH   = 8,
  parameter int unsigned GAP_CYC   = 16,
  parameter int unsigned LAUNCH_TO = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*D_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_en,
  output logic [D_WIDTH-1:0]           tx_data,
  input  logic                         tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         active,
  output logic                         err_pulse,
  output logic [15:0]                  frame_cnt
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned GapW = $clog2(GAP_CYC + 2);
  localparam int unsigned ToW  = $clog2(LAUNCH_TO);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(LAUNCH_TO - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWaitDone, StGap} state_e;

  state_e               state_q, state_d;
  logic [IdW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic                 tx_en_q, tx_en_d;
  logic [D_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic [IdW-1:0]       grant_q, grant_d;
  logic                 active_q, active_d;
  logic                 err_q, err_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic [ToW-1:0]       to_q, to_d;

  logic [IdW-1:0]       win;
  logic [IdW-1:0]       idx;
  logic                 any_valid;
  logic [D_WIDTH-1:0]   win_data;

  // Scan ptr+1, ptr+2, ... so the last winner gets lowest priority next time.
  always_comb begin
    win       = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IdW'((32'(ptr_q) + k) % NUM_REQ);
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        win       = idx;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == IdW'(i)) win_data = req_data[i*D_WIDTH +: D_WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ready_d     = '0;
    tx_en_d     = tx_en_q;
    tx_data_d   = tx_data_q;
    grant_d     = grant_q;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    gap_d       = gap_q;
    to_d        = to_q;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) ready_d[i] = (win == IdW'(i));
          tx_data_d = win_data;
          grant_d   = win;
          ptr_d     = win;
          tx_en_d   = 1'b1;
          to_d      = '0;
          state_d   = StLaunch;
        end
      end
      StLaunch: begin
        if (tx_busy) begin
          tx_en_d = 1'b0;
          to_d    = '0;
          state_d = StWaitDone;
        end else if (to_q == ToLast) begin
          // Transmitter never answered: drop the frame and still honour the gap.
          tx_en_d = 1'b0;
          err_d   = 1'b1;
          to_d    = '0;
          gap_d   = '0;
          state_d = StGap;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          gap_d       = '0;
          state_d     = (GAP_CYC == 0) ? StIdle : StGap;
        end
      end
      StGap: begin
        if (GAP_CYC == 0 || gap_q == GapLast) state_d = StIdle;
        else                                  gap_d   = gap_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
    active_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      ptr_q       <= IdW'(NUM_REQ - 1);
      ready_q     <= '0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= '0;
      grant_q     <= '0;
      active_q    <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      gap_q       <= '0;
      to_q        <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ready_q     <= ready_d;
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
      grant_q     <= grant_d;
      active_q    <= active_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      gap_q       <= gap_d;
      to_q        <= to_d;
    end
  end

  assign req_ready = ready_q;
  assign tx_en     = tx_en_q;
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_q;
  assign active    = active_q;
  assign err_pulse = err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: behavioural model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_uart_tx_arbiter;
  localparam int NR = 4, DW = 8, GAP = 16, LTO = 8, FRAME = 5;
  localparam int PIdle = 0, PLaunch = 1, PXmit = 2, PGap = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data  = '0;
  logic [NR-1:0]    req_ready;
  logic             tx_en;
  logic [DW-1:0]    tx_data;
  logic             tx_busy = 1'b0;
  logic [1:0]       grant_id;
  logic             active;
  logic             err_pulse;
  logic [15:0]      frame_cnt;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .D_WIDTH(DW), .GAP_CYC(GAP), .LAUNCH_TO(LTO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id),
    .active(active), .err_pulse(err_pulse), .frame_cnt(frame_cnt)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural transmitter: answers tx_en with busy for FRAME cycles (mode 1) or never (mode 0).
  int busy_mode = 1;
  int busy_left = 0;
  int fall_cyc  = 0;
  always @(negedge clk) begin
    if (busy_mode == 0) begin
      tx_busy   = 1'b0;
      busy_left = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        tx_busy  = 1'b0;
        fall_cyc = cyc;
      end
    end else if (tx_en === 1'b1 && !tx_busy) begin
      tx_busy   = 1'b1;
      busy_left = FRAME;
    end
  end

  // Reference model, stepped on every clock edge from the sampled inputs.
  bit            model_ok = 0;
  bit            frames_load = 0;
  int            m_phase, m_ptr, m_wait, m_frames, w;
  logic [NR-1:0] e_ready;
  logic          e_en, e_err, e_active;
  logic [DW-1:0] e_data;
  int            e_gid;

  always @(posedge clk) begin
    if (!rst) begin
      m_phase = PIdle; m_ptr = NR - 1; m_wait = 0; m_frames = 0;
      e_ready = '0; e_en = 0; e_err = 0; e_data = '0; e_gid = 0;
      model_ok = 1;
    end else begin
      if (frames_load) m_frames = 16'hFFFF;
      e_ready = '0;
      e_err   = 0;
      case (m_phase)
        PIdle: if (req_valid != 0) begin
          w = -1;
          for (int k = 1; k <= NR; k++)
            if (w < 0 && req_valid[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
          e_ready[w] = 1'b1;
          e_data     = req_data[w*DW +: DW];
          e_gid      = w;
          m_ptr      = w;
          e_en       = 1;
          m_wait     = 0;
          m_phase    = PLaunch;
        end
        PLaunch: begin
          if (tx_busy) begin
            e_en = 0; m_phase = PXmit;
          end else begin
            m_wait++;
            if (m_wait == LTO) begin
              e_en = 0; e_err = 1; m_wait = 0; m_phase = PGap;
            end
          end
        end
        PXmit: if (!tx_busy) begin
          m_frames = (m_frames + 1) % 65536;
          m_wait   = 0;
          m_phase  = (GAP == 0) ? PIdle : PGap;
        end
        default: begin
          m_wait++;
          if (m_wait >= GAP) m_phase = PIdle;
        end
      endcase
    end
    e_active = (m_phase != PIdle);
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("tx_en",     32'(tx_en),     32'(e_en));
      check("tx_data",   32'(tx_data),   32'(e_data));
      check("grant_id",  32'(grant_id),  32'(e_gid));
      check("active",    32'(active),    32'(e_active));
      check("err_pulse", 32'(err_pulse), 32'(e_err));
      check("frame_cnt", 32'(frame_cnt), 32'(m_frames[15:0]));
    end
  end

  task automatic wait_ready(input int max, input string name);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (|req_ready) return;
    end
    check(name, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int max, input string name);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!active) return;
    end
    check(name, 32'd0, 32'd1);
  endtask

  logic [1:0]    exp_gid [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [DW-1:0] exp_dat [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
  int n, r1, r2, ec, en_cnt;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_active", 32'(active), 32'd0);
    check("rst_frames", 32'(frame_cnt), 32'd0);
    check("rst_tx_en",  32'(tx_en), 32'd0);

    // Single requester, one frame.
    req_data  = {8'h00, 8'h00, 8'h00, 8'hA5};
    req_valid = 4'b0001;
    wait_ready(10, "t1_ready_timeout");
    check("t1_ready", 32'(req_ready), 32'h1);
    check("t1_data",  32'(tx_data), 32'hA5);
    check("t1_en",    32'(tx_en), 32'd1);
    req_valid = '0;
    wait_idle(100, "t1_idle_timeout");
    check("t1_frames", 32'(frame_cnt), 32'd1);

    // All requesters held: rotation from a fresh reset, gap timing after each busy fall.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    n = 0;
    for (int i = 0; i < 300 && n < 5; i++) begin
      @(negedge clk);
      if (|req_ready) begin
        check("t2_gid",  32'(grant_id), 32'(exp_gid[n]));
        check("t2_data", 32'(tx_data),  32'(exp_dat[n]));
        if (n > 0) check("t2_gap", 32'(cyc - fall_cyc), 32'd18);
        n++;
      end
    end
    check("t2_grants", 32'(n), 32'd5);
    req_valid = '0;
    wait_idle(100, "t2_idle_timeout");
    check("t2_frames", 32'(frame_cnt), 32'd5);

    // Transmitter silent: watchdog abort, then the held request is re-granted after the gap.
    busy_mode = 0;
    req_data  = {8'h00, 8'h33, 8'h00, 8'h00};
    req_valid = 4'b0100;
    wait_ready(10, "t3_ready_timeout");
    check("t3_gid", 32'(grant_id), 32'd2);
    r1 = cyc; en_cnt = 1; ec = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (err_pulse) begin ec = cyc; break; end
      if (tx_en) en_cnt++;
    end
    busy_mode = 1;
    check("t3_en_cycles", 32'(en_cnt), 32'd8);
    check("t3_err_at", 32'(ec - r1), 32'd8);
    wait_ready(60, "t3_ready2_timeout");
    r2 = cyc;
    check("t3_regrant", 32'(r2 - r1), 32'd25);
    check("t3_after_err", 32'(r2 - ec), 32'd17);
    check("t3_frames_kept", 32'(frame_cnt), 32'd5);
    req_valid = '0;
    wait_idle(100, "t3_idle_timeout");
    check("t3_frames", 32'(frame_cnt), 32'd6);

    // Reset while waiting for the transmitter to finish.
    req_data  = {8'h44, 8'h00, 8'h22, 8'h77};
    req_valid = 4'b0001;
    wait_ready(10, "t4_ready_timeout");
    req_valid = '0;
    repeat (2) @(negedge clk);
    check("t4_busy_seen", 32'(tx_busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("t4_rst_en",     32'(tx_en), 32'd0);
    check("t4_rst_data",   32'(tx_data), 32'd0);
    check("t4_rst_active", 32'(active), 32'd0);
    check("t4_rst_frames", 32'(frame_cnt), 32'd0);
    check("t4_rst_gid",    32'(grant_id), 32'd0);
    rst = 1'b1;
    req_valid = 4'b1010;
    wait_ready(10, "t4_ready2_timeout");
    check("t4_lowest", 32'(req_ready), 32'h2);
    check("t4_gid",    32'(grant_id), 32'd1);
    check("t4_data",   32'(tx_data), 32'h22);
    req_valid = '0;
    wait_idle(100, "t4_idle_timeout");

    // Frame counter wrap.
    @(negedge clk);
    #1 force dut.frame_cnt_q = 16'hFFFF;
    frames_load = 1;
    @(negedge clk);
    #1 release dut.frame_cnt_q;
    frames_load = 0;
    @(negedge clk);
    check("t5_preload", 32'(frame_cnt), 32'hFFFF);
    req_data  = {8'h00, 8'h00, 8'h00, 8'h5A};
    req_valid = 4'b0001;
    wait_ready(10, "t5_ready_timeout");
    req_valid = '0;
    wait_idle(100, "t5_idle_timeout");
    check("t5_wrap", 32'(frame_cnt), 32'h0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
